// File: rtl/mux_sched_pkg.sv
// Shared defaults and arbiter state encoding for the two-lane round-robin scheduler.
package mux_sched_pkg;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned CNT_W      = 3;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] SEND0 = 2'b01;
  localparam logic [1:0] SEND1 = 2'b10;

endpackage

// File: rtl/mux_rr_scheduler_sync_fifo.sv
// Per-lane synchronous FIFO with registered occupancy count and no write-to-read bypass.
module sync_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = 3
) (
  input  logic              clk8f,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              push_ok, pop_ok;

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  // Fullness comes from the registered count, so a push into a full FIFO drops even on a pop.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign count   = cnt_q;
  assign dout    = mem_q[rptr_q];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push_ok) wptr_d = wptr_q + AW'(1);
    if (pop_ok)  rptr_d = rptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk8f or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk8f) begin
    if (push_ok) mem_q[wptr_q] <= din;
  end

endmodule

// File: rtl/mux_rr_scheduler.sv
// Two-lane round-robin scheduler: per-lane FIFOs feeding a registered, backpressured output.
module mux_rr_scheduler
  import mux_sched_pkg::*;
#(
  parameter int unsigned DATA_W     = mux_sched_pkg::DATA_W,
  parameter int unsigned FIFO_DEPTH = mux_sched_pkg::FIFO_DEPTH,
  parameter int unsigned CNT_W      = mux_sched_pkg::CNT_W
) (
  input  logic              clk8f,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in_0,
  input  logic              valid_in_0,
  output logic              ready_0,
  input  logic [DATA_W-1:0] data_in_1,
  input  logic              valid_in_1,
  output logic              ready_1,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              sel_out,
  output logic [CNT_W-1:0]  fifo_count_0,
  output logic [CNT_W-1:0]  fifo_count_1,
  output logic              overflow_0,
  output logic              overflow_1
);

  logic [DATA_W-1:0] dout_0, dout_1;
  logic              full_0, full_1, empty_0, empty_1;
  logic              pop_0, pop_1;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              sel_q, sel_d;
  logic              last_grant_q, last_grant_d;
  logic [1:0]        overflow_q, overflow_d;
  logic              adv, grant_vld, grant_lane;

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_fifo_0 (
    .clk8f (clk8f),
    .reset (reset),
    .push  (valid_in_0),
    .din   (data_in_0),
    .pop   (pop_0),
    .dout  (dout_0),
    .count (fifo_count_0),
    .full  (full_0),
    .empty (empty_0)
  );

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_fifo_1 (
    .clk8f (clk8f),
    .reset (reset),
    .push  (valid_in_1),
    .din   (data_in_1),
    .pop   (pop_1),
    .dout  (dout_1),
    .count (fifo_count_1),
    .full  (full_1),
    .empty (empty_1)
  );

  assign valid_out = (state_q != IDLE);
  assign adv       = ~valid_out | out_ready;

  always_comb begin
    grant_vld  = 1'b0;
    grant_lane = 1'b0;
    if (adv) begin
      if (!empty_0 && !empty_1) begin
        grant_vld  = 1'b1;
        grant_lane = ~last_grant_q;
      end else if (!empty_0) begin
        grant_vld  = 1'b1;
        grant_lane = 1'b0;
      end else if (!empty_1) begin
        grant_vld  = 1'b1;
        grant_lane = 1'b1;
      end
    end
  end

  assign pop_0 = grant_vld & ~grant_lane;
  assign pop_1 = grant_vld & grant_lane;

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    sel_d        = sel_q;
    last_grant_d = last_grant_q;
    if (adv) begin
      if (grant_vld) begin
        state_d      = grant_lane ? SEND1 : SEND0;
        data_d       = grant_lane ? dout_1 : dout_0;
        sel_d        = grant_lane;
        last_grant_d = grant_lane;
      end else begin
        // Going idle keeps data_out/sel_out at their last values.
        state_d = IDLE;
      end
    end
    overflow_d = overflow_q | {valid_in_1 & full_1, valid_in_0 & full_0};
  end

  always_ff @(posedge clk8f or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      data_q       <= '0;
      sel_q        <= 1'b0;
      last_grant_q <= 1'b1;
      overflow_q   <= '0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      sel_q        <= sel_d;
      last_grant_q <= last_grant_d;
      overflow_q   <= overflow_d;
    end
  end

  assign ready_0    = ~full_0;
  assign ready_1    = ~full_1;
  assign data_out   = data_q;
  assign sel_out    = sel_q;
  assign overflow_0 = overflow_q[0];
  assign overflow_1 = overflow_q[1];

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Self-checking bench for mux_rr_scheduler: vector table, directed corner cases, random vs. queue model.
module tb_mux_rr_scheduler;

  logic       clk8f = 1'b0;
  logic       reset;
  logic [7:0] data_in_0, data_in_1;
  logic       valid_in_0, valid_in_1, out_ready;
  logic       ready_0, ready_1;
  logic [7:0] data_out;
  logic       valid_out, sel_out;
  logic [2:0] fifo_count_0, fifo_count_1;
  logic       overflow_0, overflow_1;

  int pass_cnt = 0;
  int total_cnt = 0;

  mux_rr_scheduler dut (
    .clk8f        (clk8f),
    .reset        (reset),
    .data_in_0    (data_in_0),
    .valid_in_0   (valid_in_0),
    .ready_0      (ready_0),
    .data_in_1    (data_in_1),
    .valid_in_1   (valid_in_1),
    .ready_1      (ready_1),
    .out_ready    (out_ready),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .sel_out      (sel_out),
    .fifo_count_0 (fifo_count_0),
    .fifo_count_1 (fifo_count_1),
    .overflow_0   (overflow_0),
    .overflow_1   (overflow_1)
  );

  always #5 clk8f = ~clk8f;

  // Reference model: one queue per lane plus the registered output view.
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] m_data;
  logic       m_valid, m_sel, m_last, m_ov0, m_ov1;

  task automatic model_reset();
    q0.delete();
    q1.delete();
    m_data  = 8'h00;
    m_valid = 1'b0;
    m_sel   = 1'b0;
    m_last  = 1'b1;
    m_ov0   = 1'b0;
    m_ov1   = 1'b0;
  endtask

  task automatic model_edge(input logic v0, input logic [7:0] d0, input logic v1,
                            input logic [7:0] d1, input logic ordy);
    bit room0, room1, lane, take;
    room0 = (q0.size() < 4);
    room1 = (q1.size() < 4);
    take  = 1'b0;
    lane  = 1'b0;
    if (!m_valid || ordy) begin
      if (q0.size() > 0 && q1.size() > 0) begin
        take = 1'b1;
        lane = !m_last;
      end else if (q0.size() > 0) begin
        take = 1'b1;
        lane = 1'b0;
      end else if (q1.size() > 0) begin
        take = 1'b1;
        lane = 1'b1;
      end
      if (take) begin
        m_data  = lane ? q1.pop_front() : q0.pop_front();
        m_valid = 1'b1;
        m_sel   = lane;
        m_last  = lane;
      end else begin
        m_valid = 1'b0;
      end
    end
    if (v0) begin
      if (room0) q0.push_back(d0);
      else m_ov0 = 1'b1;
    end
    if (v1) begin
      if (room1) q1.push_back(d1);
      else m_ov1 = 1'b1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, " data_out"}, 32'(data_out), 32'(m_data));
    chk({tag, " valid_out"}, 32'(valid_out), 32'(m_valid));
    chk({tag, " sel_out"}, 32'(sel_out), 32'(m_sel));
    chk({tag, " count0"}, 32'(fifo_count_0), 32'(q0.size()));
    chk({tag, " count1"}, 32'(fifo_count_1), 32'(q1.size()));
    chk({tag, " ready0"}, 32'(ready_0), 32'(q0.size() < 4));
    chk({tag, " ready1"}, 32'(ready_1), 32'(q1.size() < 4));
    chk({tag, " overflow0"}, 32'(overflow_0), 32'(m_ov0));
    chk({tag, " overflow1"}, 32'(overflow_1), 32'(m_ov1));
  endtask

  task automatic step(input logic v0, input logic [7:0] d0, input logic v1,
                      input logic [7:0] d1, input logic ordy, input string tag);
    valid_in_0 = v0;
    data_in_0  = d0;
    valid_in_1 = v1;
    data_in_1  = d1;
    out_ready  = ordy;
    model_edge(v0, d0, v1, d1, ordy);
    @(posedge clk8f);
    #1;
    chk_model(tag);
  endtask

  task automatic do_reset();
    valid_in_0 = 1'b0;
    valid_in_1 = 1'b0;
    data_in_0  = 8'h00;
    data_in_1  = 8'h00;
    out_ready  = 1'b0;
    @(posedge clk8f);
    #2;
    reset = 1'b0;
    #2;
    reset = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic       v0;
    logic [7:0] d0;
    logic       v1;
    logic [7:0] d1;
    logic       ordy;
    logic [7:0] e_data;
    logic       e_valid;
    logic       e_sel;
    logic [2:0] e_c0;
    logic [2:0] e_c1;
    logic       e_r1;
    logic       e_ov1;
  } vec_t;

  vec_t vecs[16];

  initial begin
    // Lane 0 only, then lane 1 under backpressure with overflow and drain.
    vecs[0]  = '{1'b1, 8'hA1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 3'd1, 3'd0, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 8'hA2, 1'b0, 8'h00, 1'b1, 8'hA1, 1'b1, 1'b0, 3'd1, 3'd0, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 8'hA3, 1'b0, 8'h00, 1'b1, 8'hA2, 1'b1, 1'b0, 3'd1, 3'd0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'hA3, 1'b1, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'hA3, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 8'h30, 1'b0, 8'hA3, 1'b0, 1'b0, 3'd0, 3'd1, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 8'h31, 1'b0, 8'h30, 1'b1, 1'b1, 3'd0, 3'd1, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 8'h32, 1'b0, 8'h30, 1'b1, 1'b1, 3'd0, 3'd2, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 8'h33, 1'b0, 8'h30, 1'b1, 1'b1, 3'd0, 3'd3, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 8'h34, 1'b0, 8'h30, 1'b1, 1'b1, 3'd0, 3'd4, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 8'h35, 1'b0, 8'h30, 1'b1, 1'b1, 3'd0, 3'd4, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h31, 1'b1, 1'b1, 3'd0, 3'd3, 1'b1, 1'b1};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h32, 1'b1, 1'b1, 3'd0, 3'd2, 1'b1, 1'b1};
    vecs[13] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h33, 1'b1, 1'b1, 3'd0, 3'd1, 1'b1, 1'b1};
    vecs[14] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h34, 1'b1, 1'b1, 3'd0, 3'd0, 1'b1, 1'b1};
    vecs[15] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h34, 1'b0, 1'b1, 3'd0, 3'd0, 1'b1, 1'b1};

    reset      = 1'b0;
    valid_in_0 = 1'b0;
    valid_in_1 = 1'b0;
    data_in_0  = 8'h00;
    data_in_1  = 8'h00;
    out_ready  = 1'b0;
    model_reset();
    #12;
    chk("reset data_out", 32'(data_out), 32'h0);
    chk("reset valid_out", 32'(valid_out), 32'h0);
    chk("reset sel_out", 32'(sel_out), 32'h0);
    chk("reset count0", 32'(fifo_count_0), 32'h0);
    chk("reset count1", 32'(fifo_count_1), 32'h0);
    chk("reset ready0", 32'(ready_0), 32'h1);
    chk("reset overflow1", 32'(overflow_1), 32'h0);
    reset = 1'b1;

    for (int i = 0; i < 16; i++) begin
      step(vecs[i].v0, vecs[i].d0, vecs[i].v1, vecs[i].d1, vecs[i].ordy, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d exp data_out", i), 32'(data_out), 32'(vecs[i].e_data));
      chk($sformatf("vec%0d exp valid_out", i), 32'(valid_out), 32'(vecs[i].e_valid));
      chk($sformatf("vec%0d exp sel_out", i), 32'(sel_out), 32'(vecs[i].e_sel));
      chk($sformatf("vec%0d exp count0", i), 32'(fifo_count_0), 32'(vecs[i].e_c0));
      chk($sformatf("vec%0d exp count1", i), 32'(fifo_count_1), 32'(vecs[i].e_c1));
      chk($sformatf("vec%0d exp ready1", i), 32'(ready_1), 32'(vecs[i].e_r1));
      chk($sformatf("vec%0d exp overflow1", i), 32'(overflow_1), 32'(vecs[i].e_ov1));
    end

    // Both lanes every cycle: grant alternates starting with lane 0.
    do_reset();
    begin
      logic [7:0] exp_d [4];
      exp_d[0] = 8'h10; exp_d[1] = 8'h20; exp_d[2] = 8'h11; exp_d[3] = 8'h21;
      step(1'b1, 8'h10, 1'b1, 8'h20, 1'b1, "alt e1");
      for (int i = 0; i < 4; i++) begin
        step(1'b1, 8'(8'h11 + i), 1'b1, 8'(8'h21 + i), 1'b1, $sformatf("alt e%0d", i + 2));
        chk($sformatf("alt word%0d data", i), 32'(data_out), 32'(exp_d[i]));
        chk($sformatf("alt word%0d sel", i), 32'(sel_out), 32'(i % 2));
      end
    end

    // Same-cycle push/pop on lane 0 at count 2.
    do_reset();
    step(1'b1, 8'h50, 1'b0, 8'h00, 1'b0, "pp e1");
    step(1'b1, 8'h51, 1'b0, 8'h00, 1'b0, "pp e2");
    step(1'b1, 8'h52, 1'b0, 8'h00, 1'b0, "pp e3");
    chk("pp count before", 32'(fifo_count_0), 32'd2);
    step(1'b1, 8'h55, 1'b0, 8'h00, 1'b1, "pp e4");
    chk("pp count held", 32'(fifo_count_0), 32'd2);
    chk("pp pop 51", 32'(data_out), 32'h51);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, "pp e5");
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, "pp e6");
    chk("pp 55 emerges", 32'(data_out), 32'h55);

    // Tie after idle with last_grant=0: lane 1 wins.
    do_reset();
    step(1'b1, 8'h07, 1'b0, 8'h00, 1'b1, "tie e1");
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, "tie e2");
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, "tie e3");
    chk("tie idle", 32'(valid_out), 32'h0);
    step(1'b1, 8'h01, 1'b1, 8'h02, 1'b1, "tie e4");
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, "tie e5");
    chk("tie first data", 32'(data_out), 32'h02);
    chk("tie first sel", 32'(sel_out), 32'h1);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, "tie e6");
    chk("tie second data", 32'(data_out), 32'h01);
    chk("tie second sel", 32'(sel_out), 32'h0);

    // Reset mid-stream between edges.
    do_reset();
    step(1'b1, 8'h60, 1'b0, 8'h00, 1'b0, "mid e1");
    step(1'b1, 8'h61, 1'b0, 8'h00, 1'b0, "mid e2");
    step(1'b1, 8'h62, 1'b0, 8'h00, 1'b0, "mid e3");
    step(1'b1, 8'h63, 1'b0, 8'h00, 1'b0, "mid e4");
    chk("mid pre count0", 32'(fifo_count_0), 32'd3);
    valid_in_0 = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("mid rst data_out", 32'(data_out), 32'h0);
    chk("mid rst valid_out", 32'(valid_out), 32'h0);
    chk("mid rst count0", 32'(fifo_count_0), 32'h0);
    reset = 1'b1;
    model_reset();
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, "mid post1");
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, "mid post2");
    chk("mid no stale", 32'(valid_out), 32'h0);

    // Random traffic against the queue model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 99) < 60), 8'($urandom), 1'($urandom_range(0, 99) < 55),
           8'($urandom), 1'($urandom_range(0, 99) < 65), $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
